// File: rtl/montgomery_constant_feeder_if.sv
// Load, handshake and constant-stream signals between the host/consumer side
// and the Montgomery constant feeder.
interface montgomery_constant_feeder_if #(
    parameter int REGISTER_SIZE = 32
);
    logic                     load_start_in;
    logic                     load_valid_in;
    logic                     load_sel_in;
    logic [REGISTER_SIZE-1:0] load_block_in;
    logic                     ready_out;
    logic                     restart_in;
    logic                     consumed_k_in;
    logic [REGISTER_SIZE-1:0] k_block_out;
    logic                     consumed_N_in;
    logic [REGISTER_SIZE-1:0] n_block_out;
    logic                     k_wrap_out;
    logic                     n_wrap_out;
    logic [1:0]               n_pass_out;
    logic                     error_out;

    modport master (
        output load_start_in, load_valid_in, load_sel_in, load_block_in,
               restart_in, consumed_k_in, consumed_N_in,
        input  ready_out, k_block_out, n_block_out, k_wrap_out, n_wrap_out,
               n_pass_out, error_out
    );

    modport slave (
        input  load_start_in, load_valid_in, load_sel_in, load_block_in,
               restart_in, consumed_k_in, consumed_N_in,
        output ready_out, k_block_out, n_block_out, k_wrap_out, n_wrap_out,
               n_pass_out, error_out
    );
endinterface

// File: rtl/montgomery_constant_feeder.sv
// Stores the Montgomery constants k and N block-serially and streams them one
// block per consume pulse, wrapping to block 0 after the last block.
module montgomery_constant_feeder #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    montgomery_constant_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_BLOCKS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BLOCKS);

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t state_reg, state_next;
    logic   ready_reg;
    logic   error_reg;
    logic [1:0] n_pass_reg;

    logic       loading, in_ready, wr_ok, restart_go, enter_ready, error_set;
    logic [1:0] consume_req, consume_go;
    logic [1:0] wr_en, full, full_next, wrap_w, wrap_evt;
    logic [1:0][REGISTER_SIZE-1:0] block_w;

    assign consume_req = {bus.consumed_N_in, bus.consumed_k_in};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == READY);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.load_start_in)
            state_next = LOADING;
        else if (enter_ready)
            state_next = READY;
    end

    // load_start_in dominates everything else in its cycle.
    always_comb begin
        loading    = (state_reg == LOADING);
        in_ready   = (state_reg == READY);
        wr_ok      = loading && bus.load_valid_in && !bus.load_start_in;
        restart_go = in_ready && bus.restart_in && !bus.load_start_in;
        consume_go = (in_ready && !bus.restart_in && !bus.load_start_in) ? consume_req : 2'b00;
        error_set  = !bus.load_start_in &&
                     ((bus.load_valid_in && (!loading || full[bus.load_sel_in])) ||
                      (!in_ready && (|consume_req)));
    end

    assign enter_ready = loading && !bus.load_start_in && (&full_next);

    // Channel 0 carries k, channel 1 carries N.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];
        logic [CNT_W-1:0]         wptr_reg;
        logic [PTR_W-1:0]         ptr_reg, ptr_next;
        logic [REGISTER_SIZE-1:0] block_reg;
        logic                     wrap_reg, wrap_next, rd_en;

        // Writes are strictly sequential, so the write pointer is also the loaded count.
        assign full[gi]      = (wptr_reg == FULL_CNT);
        assign wr_en[gi]     = wr_ok && (bus.load_sel_in == 1'(gi)) && !full[gi];
        assign full_next[gi] = full[gi] || (wr_en[gi] && (wptr_reg == FULL_CNT - 1'b1));

        always_ff @(posedge clk_in) begin
            if (wr_en[gi])
                mem[wptr_reg[PTR_W-1:0]] <= bus.load_block_in;
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in)
                wptr_reg <= '0;
            else if (bus.load_start_in)
                wptr_reg <= '0;
            else if (wr_en[gi])
                wptr_reg <= wptr_reg + 1'b1;
        end

        // The final load write is never to block 0 (NUM_BLOCKS >= 2), so the
        // read of block 0 on READY entry cannot collide with it.
        always_comb begin
            ptr_next  = ptr_reg;
            rd_en     = 1'b0;
            wrap_next = 1'b0;
            if (enter_ready || restart_go) begin
                ptr_next = '0;
                rd_en    = 1'b1;
            end else if (consume_go[gi]) begin
                rd_en = 1'b1;
                if (ptr_reg == LAST_PTR) begin
                    ptr_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                ptr_reg   <= '0;
                wrap_reg  <= 1'b0;
                block_reg <= '0;
            end else begin
                ptr_reg  <= ptr_next;
                wrap_reg <= wrap_next;
                if (rd_en)
                    block_reg <= mem[ptr_next];
            end
        end

        assign block_w[gi]  = block_reg;
        assign wrap_w[gi]   = wrap_reg;
        assign wrap_evt[gi] = wrap_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            n_pass_reg <= 2'd0;
        else if (enter_ready || restart_go)
            n_pass_reg <= 2'd0;
        else if (wrap_evt[1])
            n_pass_reg <= n_pass_reg + 2'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            error_reg <= 1'b0;
        else if (bus.load_start_in)
            error_reg <= 1'b0;
        else if (error_set)
            error_reg <= 1'b1;
    end

    assign bus.ready_out   = ready_reg;
    assign bus.k_block_out = block_w[0];
    assign bus.n_block_out = block_w[1];
    assign bus.k_wrap_out  = wrap_w[0];
    assign bus.n_wrap_out  = wrap_w[1];
    assign bus.n_pass_out  = n_pass_reg;
    assign bus.error_out   = error_reg;
endmodule

// File: tb/tb_montgomery_constant_feeder.sv
// Scoreboard bench for montgomery_constant_feeder: k[i]=0x1000+i, N[i]=0x2000+i.
module tb_montgomery_constant_feeder;
    localparam int RS = 32;
    localparam int NB = 128;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    montgomery_constant_feeder_if #(.REGISTER_SIZE(RS)) bus ();

    montgomery_constant_feeder #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] k;
        logic [31:0] n;
        logic        kw;
        logic        nw;
        logic [1:0]  pass;
    } exp_t;

    exp_t sb[$];
    exp_t got, exp_v;
    int   kp = 0, np = 0;
    logic [1:0] pass_m = 2'd0;
    int   errors = 0, checks = 0;

    assign got = {bus.k_block_out, bus.n_block_out, bus.k_wrap_out, bus.n_wrap_out, bus.n_pass_out};

    function automatic exp_t model_now();
        exp_t e;
        e.k    = 32'h1000 + 32'(kp);
        e.n    = 32'h2000 + 32'(np);
        e.kw   = 1'b0;
        e.nw   = 1'b0;
        e.pass = pass_m;
        return e;
    endfunction

    function automatic exp_t model_step(input bit ck, input bit cn, input bit rs);
        exp_t e;
        bit kw = 1'b0, nw = 1'b0;
        if (rs) begin
            kp = 0; np = 0; pass_m = 2'd0;
        end else begin
            if (ck) begin
                if (kp == NB - 1) begin kp = 0; kw = 1'b1; end else kp++;
            end
            if (cn) begin
                if (np == NB - 1) begin np = 0; nw = 1'b1; pass_m = pass_m + 2'd1; end else np++;
            end
        end
        e    = model_now();
        e.kw = kw;
        e.nw = nw;
        return e;
    endfunction

    task automatic idle_inputs();
        bus.load_start_in = 1'b0; bus.load_valid_in = 1'b0; bus.load_sel_in = 1'b0;
        bus.load_block_in = '0;   bus.restart_in = 1'b0;
        bus.consumed_k_in = 1'b0; bus.consumed_N_in = 1'b0;
    endtask

    task automatic apply(input bit ck, input bit cn, input bit rs);
        bus.consumed_k_in = ck; bus.consumed_N_in = cn; bus.restart_in = rs;
        sb.push_back(model_step(ck, cn, rs));
        @(posedge clk_in); #1;
        bus.consumed_k_in = 1'b0; bus.consumed_N_in = 1'b0; bus.restart_in = 1'b0;
    endtask

    task automatic write_blk(input bit sel, input logic [31:0] d);
        bus.load_valid_in = 1'b1; bus.load_sel_in = sel; bus.load_block_in = d;
        @(posedge clk_in); #1;
        bus.load_valid_in = 1'b0;
    endtask

    task automatic pulse_load_start();
        bus.load_start_in = 1'b1;
        @(posedge clk_in); #1;
        bus.load_start_in = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #3;
        checks++; if (got !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready_out); end
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error_out); end
        $display("txn reset outputs=%h ready=%b error=%b", got, bus.ready_out, bus.error_out);
        rst_in = 1'b0;
    endtask

    task automatic test_load();
        pulse_load_start();
        for (int i = 0; i < NB; i++) begin
            write_blk(1'b0, 32'h1000 + 32'(i));
            if (i == NB - 1) begin
                checks++;
                if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL load_ready_early: got %b expected 0", bus.ready_out); end
            end
            write_blk(1'b1, 32'h2000 + 32'(i));
        end
        kp = 0; np = 0; pass_m = 2'd0;
        exp_v = model_now();
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", bus.ready_out); end
        checks++; if (got !== exp_v) begin errors++; $display("FAIL load_block0: got %h expected %h", got, exp_v); end
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL load_error: got %b expected 0", bus.error_out); end
        $display("txn load ready=%b k=%h n=%h", bus.ready_out, got.k, got.n);
    endtask

    task automatic test_stream_n();
        int wraps = 0;
        for (int i = 0; i < NB; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            if (got.nw === 1'b1) wraps++;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL stream_n #%0d: got %h expected %h", i, got, exp_v); end
            else $display("txn stream_n #%0d k=%h n=%h nw=%b pass=%0d", i, got.k, got.n, got.nw, got.pass);
        end
        checks++; if (wraps != 1) begin errors++; $display("FAIL stream_n_wraps: got %0d expected 1", wraps); end
        checks++; if (bus.n_pass_out !== 2'd1) begin errors++; $display("FAIL stream_n_pass: got %0d expected 1", bus.n_pass_out); end
    endtask

    task automatic test_restart_priority();
        for (int i = 0; i < 3 * NB; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL passes #%0d: got %h expected %h", i, got, exp_v); end
            else $display("txn passes #%0d n=%h nw=%b pass=%0d", i, got.n, got.nw, got.pass);
        end
        apply(1'b0, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++; if (got !== exp_v) begin errors++; $display("FAIL restart_prio: got %h expected %h", got, exp_v); end
        checks++;
        if (bus.n_block_out !== 32'h2000 || bus.n_pass_out !== 2'd0 || bus.n_wrap_out !== 1'b0) begin
            errors++; $display("FAIL restart_prio_n: got n=%h pass=%0d nw=%b expected 2000/0/0",
                               bus.n_block_out, bus.n_pass_out, bus.n_wrap_out);
        end
        $display("txn restart_prio n=%h pass=%0d nw=%b", got.n, got.pass, got.nw);
    endtask

    task automatic test_k_restart_dual();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL k_step #%0d: got %h expected %h", i, got, exp_v); end
            else $display("txn k_step #%0d k=%h", i, got.k);
        end
        checks++; if (bus.k_block_out !== 32'h1005) begin errors++; $display("FAIL k_five: got %h expected 1005", bus.k_block_out); end
        apply(1'b0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++; if (got !== exp_v) begin errors++; $display("FAIL k_restart: got %h expected %h", got, exp_v); end
        $display("txn k_restart k=%h", got.k);
        apply(1'b1, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (bus.k_block_out !== 32'h1001 || bus.n_block_out !== 32'h2001) begin
            errors++; $display("FAIL dual_consume: got k=%h n=%h expected 1001/2001", bus.k_block_out, bus.n_block_out);
        end
        checks++; if (got !== exp_v) begin errors++; $display("FAIL dual_model: got %h expected %h", got, exp_v); end
        $display("txn dual k=%h n=%h", got.k, got.n);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 60) == 0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL b2b #%0d: got %h expected %h", i, got, exp_v); end
            else $display("txn b2b #%0d k=%h n=%h kw=%b nw=%b pass=%0d", i, got.k, got.n, got.kw, got.nw, got.pass);
        end
    endtask

    task automatic test_errors();
        exp_v = model_now();
        pulse_load_start();
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL reload_ready: got %b expected 0", bus.ready_out); end
        checks++; if (got !== exp_v) begin errors++; $display("FAIL reload_hold: got %h expected %h", got, exp_v); end
        for (int i = 0; i < 10; i++) write_blk(1'b0, 32'h1000 + 32'(i));
        bus.consumed_k_in = 1'b1; bus.consumed_N_in = 1'b1;
        @(posedge clk_in); #1;
        bus.consumed_k_in = 1'b0; bus.consumed_N_in = 1'b0;
        checks++; if (got !== exp_v) begin errors++; $display("FAIL early_consume_hold: got %h expected %h", got, exp_v); end
        checks++; if (bus.error_out !== 1'b1) begin errors++; $display("FAIL early_consume_err: got %b expected 1", bus.error_out); end
        $display("txn early_consume error=%b", bus.error_out);
        pulse_load_start();
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL load_start_clear: got %b expected 0", bus.error_out); end
        bus.restart_in = 1'b1;
        @(posedge clk_in); #1;
        bus.restart_in = 1'b0;
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL early_restart_err: got %b expected 0", bus.error_out); end
        for (int i = 0; i < NB; i++) write_blk(1'b0, 32'h1000 + 32'(i));
        write_blk(1'b0, 32'hDEAD_BEEF);
        checks++; if (bus.error_out !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", bus.error_out); end
        $display("txn overflow_write error=%b", bus.error_out);
        for (int i = 0; i < NB; i++) write_blk(1'b1, 32'h2000 + 32'(i));
        kp = 0; np = 0; pass_m = 2'd0;
        exp_v = model_now();
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reload_ready_up: got %b expected 1", bus.ready_out); end
        checks++; if (got !== exp_v) begin errors++; $display("FAIL overflow_dropped: got %h expected %h", got, exp_v); end
        $display("txn reload k=%h n=%h", got.k, got.n);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL pre_reset #%0d: got %h expected %h", i, got, exp_v); end
            else $display("txn pre_reset #%0d k=%h n=%h", i, got.k, got.n);
        end
        #2 rst_in = 1'b1;
        #1;
        checks++; if (got !== '0) begin errors++; $display("FAIL async_reset_out: got %h expected 0", got); end
        checks++;
        if (bus.ready_out !== 1'b0 || bus.error_out !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got ready=%b error=%b expected 0/0", bus.ready_out, bus.error_out);
        end
        #2 rst_in = 1'b0;
        @(posedge clk_in); #1;
        bus.consumed_k_in = 1'b1;
        @(posedge clk_in); #1;
        bus.consumed_k_in = 1'b0;
        checks++; if (bus.error_out !== 1'b1) begin errors++; $display("FAIL post_reset_consume: got %b expected 1", bus.error_out); end
        checks++; if (got !== '0) begin errors++; $display("FAIL post_reset_hold: got %h expected 0", got); end
        $display("txn async_reset error=%b outputs=%h", bus.error_out, got);
    endtask

    initial begin
        test_reset();
        test_load();
        test_stream_n();
        test_restart_priority();
        test_k_restart_dual();
        test_back_to_back();
        test_errors();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
